// File: rtl/ram_hs_if.sv
//------------------------------------------------------------------------------
// Module   : ram_hs_if
// Brief    : Strobe/ready handshake bundle between a bus initiator and ram_hs.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_hs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  WE;
  logic                  OE;
  logic [ADDR_WIDTH-1:0] addr_bus;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (output WE, OE, addr_bus, input ready, busy, err);
  modport slave  (input WE, OE, addr_bus, output ready, busy, err);
endinterface

`default_nettype wire

// File: rtl/ram_hs.sv
//------------------------------------------------------------------------------
// Module   : ram_hs
// Brief    : Single-port RAM slave with strobe/ready handshake, programmable
//            wait states, post-reset clear sequencer and sticky strobe error.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_hs #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int WAIT_STATES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  ram_hs_if.slave              bus,
  // The shared data bus is tri-stated, so it stays a plain inout port.
  inout  wire [DATA_WIDTH-1:0] data_bus
);

  localparam int                  c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt, w_clr_nxt;
  logic [3:0]            r_wait_cnt, w_wait_nxt;
  logic                  r_op_write, w_op_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic                  w_mem_we, w_mem_re;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_cap, w_other;

  assign w_cap   = r_op_write ? bus.WE : bus.OE;
  assign w_other = r_op_write ? bus.OE : bus.WE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_clr_cnt  <= '0;
      r_wait_cnt <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_busy     <= (CLEAR_ON_RESET != 0);
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_op_write <= w_op_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_op_nxt    = r_op_write;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_wdata = r_wdata;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_cnt;
        w_mem_wdata = '0;
        w_clr_nxt   = r_clr_cnt + 1'b1;
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.WE && bus.OE) begin
          w_err_nxt = 1'b1;
        end else if (bus.WE || bus.OE) begin
          w_op_nxt    = bus.WE;
          w_addr_nxt  = bus.addr_bus;
          if (bus.WE) w_wdata_nxt = data_bus;
          // With no wait states the access completes on the capture edge.
          w_mem_addr  = bus.addr_bus;
          w_mem_wdata = data_bus;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_DONE;
            w_ready_nxt = 1'b1;
            w_mem_we    = bus.WE;
            w_mem_re    = bus.OE;
          end else begin
            w_wait_nxt  = 4'(WAIT_STATES);
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_other) w_err_nxt = 1'b1;
        if (!w_cap) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt - 1'b1;
          if (r_wait_cnt == 4'd1) begin
            w_state_nxt = S_DONE;
            w_ready_nxt = 1'b1;
            w_mem_we    = r_op_write;
            w_mem_re    = !r_op_write;
          end
        end
      end
      S_DONE: begin
        if (w_other) w_err_nxt = 1'b1;
        if (!w_cap) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Array and read register carry no reset; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    if (rst_n && w_mem_re) r_rdata <= r_mem[w_mem_addr];
  end

  assign data_bus  = (r_state == S_DONE && !r_op_write && bus.OE) ? r_rdata : {DATA_WIDTH{1'bz}};
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_hs.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_hs
// Brief    : Randomised scoreboard bench for ram_hs (2 wait states with clear,
//            and 0 wait states without clear).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_hs_if #(.ADDR_WIDTH(4)) aif ();
  ram_hs_if #(.ADDR_WIDTH(4)) bif ();
  wire  [7:0] dbus_a, dbus_b;
  logic [7:0] drv_a = '0, drv_b = '0;
  logic       den_a = 1'b0, den_b = 1'b0;
  assign dbus_a = den_a ? drv_a : 8'bz;
  assign dbus_b = den_b ? drv_b : 8'bz;

  ram_hs #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(2), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(aif), .data_bus(dbus_a));
  ram_hs #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bif), .data_bus(dbus_b));

  int n_checks = 0, n_pass = 0;
  logic [7:0] mdl_a [16];
  logic [7:0] mdl_b [16];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  bit   seen_a = 0, seen_b = 0;
  int   busy_b_cycles = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input bit b, input logic we, input logic oe, input logic [3:0] a,
                       input logic [7:0] d, input logic den);
    if (b) begin bif.WE = we; bif.OE = oe; bif.addr_bus = a; drv_b = d; den_b = den; end
    else   begin aif.WE = we; aif.OE = oe; aif.addr_bus = a; drv_a = d; den_a = den; end
  endtask

  function automatic logic rdy(input bit b);
    return b ? bif.ready : aif.ready;
  endfunction

  function automatic logic [7:0] bus_val(input bit b);
    return b ? dbus_b : dbus_a;
  endfunction

  // One complete handshake: strobe, wait for ready, release, confirm ready drops.
  task automatic access(input bit b, input bit wr, input logic [3:0] a, input logic [7:0] d);
    int n;
    if (!wr) begin
      if (b) q_b.push_back(mdl_b[a]);
      else   q_a.push_back(mdl_a[a]);
    end
    drive(b, wr, !wr, a, d, wr);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy(b) && n < 20);
    chk(b ? "b_latency" : "a_latency", n, b ? 1 : 3);
    if (wr) begin
      if (b) mdl_b[a] = d;
      else   mdl_a[a] = d;
    end
    // Drive zero onto the bus once OE is low: a still-driving slave would corrupt it.
    drive(b, 1'b0, 1'b0, a, 8'h00, 1'b1);
    #1;
    if (!wr) chk(b ? "b_release" : "a_release", bus_val(b), 8'h00);
    @(negedge clk);
    chk(b ? "b_ready_fall" : "a_ready_fall", rdy(b), 1'b0);
    drive(b, 1'b0, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (aif.busy && n < 40) begin @(negedge clk); n++; end
    chk(name, n, 16);
    for (int i = 0; i < 16; i++) mdl_a[i] = 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", aif.ready, 1'b0);
    chk("rst_err", aif.err, 1'b0);
    chk("rst_busy", aif.busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clear_len");
  endtask

  always @(posedge clk) begin
    #2;
    if (aif.ready && aif.OE) begin
      if (!seen_a) begin
        seen_a = 1;
        if (q_a.size() == 0) chk("a_rd_unexpected", 1, 0);
        else chk("a_rd_data", dbus_a, q_a.pop_front());
      end
    end else seen_a = 0;
    if (bif.ready && bif.OE) begin
      if (!seen_b) begin
        seen_b = 1;
        if (q_b.size() == 0) chk("b_rd_unexpected", 1, 0);
        else chk("b_rd_data", dbus_b, q_b.pop_front());
      end
    end else seen_b = 0;
  end

  always @(negedge clk) if (bif.busy) busy_b_cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    drive(0, 0, 0, 4'h0, 8'h00, 0);
    drive(1, 0, 0, 4'h0, 8'h00, 0);
    #12;
    chk("init_ready", aif.ready, 1'b0);
    chk("init_err", aif.err, 1'b0);
    chk("init_busy", aif.busy, 1'b1);
    chk("init_b_busy", bif.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("init_clear_len");

    // Fill with 0xFF, reset, and expect every word cleared.
    for (int i = 0; i < 16; i++) access(0, 1, 4'(i), 8'hFF);
    access(0, 0, 4'h5, 8'h00);
    pulse_reset();
    for (int i = 0; i < 16; i++) access(0, 0, 4'(i), 8'h00);

    access(0, 1, 4'h3, 8'hA5);
    access(0, 0, 4'h3, 8'h00);

    // Write aborted after one cycle in WAIT: never completes, nothing stored.
    drive(0, 1, 0, 4'h7, 8'h5A, 1);
    seen = 0;
    repeat (2) begin @(negedge clk); if (aif.ready) seen++; end
    drive(0, 0, 0, 4'h7, 8'h00, 0);
    repeat (6) begin @(negedge clk); if (aif.ready) seen++; end
    chk("abort_ready", seen, 0);
    access(0, 0, 4'h7, 8'h00);

    // Both strobes together: no access, sticky error.
    drive(0, 1, 1, 4'h2, 8'h00, 0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (aif.ready) seen++; end
    drive(0, 0, 0, 4'h2, 8'h00, 0);
    repeat (4) begin @(negedge clk); if (aif.ready) seen++; end
    chk("dual_ready", seen, 0);
    chk("dual_err", aif.err, 1'b1);
    access(0, 1, 4'h9, 8'h3C);
    access(0, 0, 4'h9, 8'h00);
    chk("err_sticky", aif.err, 1'b1);
    pulse_reset();
    chk("err_cleared", aif.err, 1'b0);

    // Reset while the clear counter sits at 9: sequence restarts from 0.
    access(0, 1, 4'hC, 8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midclr_busy", aif.busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("midclr_len");
    access(0, 0, 4'hC, 8'h00);

    for (int i = 0; i < 40; i++)
      access(0, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));

    // Zero-wait-state instance, back-to-back at the minimum period.
    access(1, 1, 4'h0, 8'h11);
    access(1, 1, 4'h1, 8'h22);
    access(1, 0, 4'h0, 8'h00);
    access(1, 0, 4'h1, 8'h00);
    for (int i = 2; i < 16; i++) access(1, 1, 4'(i), 8'($urandom));
    for (int i = 0; i < 40; i++)
      access(1, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));

    repeat (3) @(negedge clk);
    chk("b_busy_never", busy_b_cycles, 0);
    chk("a_sb_drained", q_a.size(), 0);
    chk("b_sb_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
